// File: rtl/fpgaminer_avmm_work_regs.sv
// Avalon-MM register block that stages a mining work packet for the hash core
// and buffers golden nonces coming back from it.
module fpgaminer_avmm_work_regs #(
  parameter int FIFO_DEPTH = 4,
  parameter bit W1C_ENABLE = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [3:0]   avs_address,
  input  logic         avs_write,
  input  logic [31:0]  avs_writedata,
  input  logic [3:0]   avs_byteenable,
  input  logic         avs_read,
  output logic [31:0]  avs_readdata,
  output logic         work_valid,
  input  logic         work_ready,
  output logic [255:0] work_midstate,
  output logic [95:0]  work_data,
  input  logic         nonce_valid,
  input  logic [31:0]  nonce
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = 5;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [3:0] ADDR_CTRL   = 4'd11;
  localparam logic [3:0] ADDR_STATUS = 4'd12;
  localparam logic [3:0] ADDR_POP    = 4'd13;

  logic [31:0]      shadow_reg [0:10];
  logic [31:0]      packet_reg [0:10];
  logic [31:0]      fifo_mem [0:FIFO_DEPTH-1];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             pending_reg, overflow_reg, commit_err_reg;
  logic [31:0]      readdata_reg, rd_mux, status_word;

  logic commit, accept, load, pop, push, fifo_empty, fifo_full;
  logic ovf_set, cerr_set, status_wr, ovf_clr, cerr_clr;

  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == FULL_CNT);
  assign commit     = avs_write && (avs_address == ADDR_CTRL) && avs_byteenable[0] && avs_writedata[0];
  assign accept     = pending_reg && work_ready;
  // A commit may reload the packet only when the slot is free or being emptied this cycle.
  assign load       = commit && (!pending_reg || accept);
  assign cerr_set   = commit && pending_reg && !work_ready;
  assign pop        = avs_read && (avs_address == ADDR_POP) && !fifo_empty;
  assign push       = nonce_valid && (!fifo_full || pop);
  assign ovf_set    = nonce_valid && fifo_full && !pop;
  assign status_wr  = W1C_ENABLE && avs_write && (avs_address == ADDR_STATUS);
  assign ovf_clr    = status_wr && avs_byteenable[0] && avs_writedata[7];
  assign cerr_clr   = status_wr && avs_byteenable[1] && avs_writedata[8];

  assign status_word = {23'b0, commit_err_reg, overflow_reg, count_reg, !fifo_empty, pending_reg};

  genvar gi;
  generate
    for (gi = 0; gi < 11; gi++) begin : g_word
      always_ff @(posedge clk) begin
        if (reset) begin
          shadow_reg[gi] <= '0;
        end else if (avs_write && (avs_address == 4'(gi))) begin
          for (int b = 0; b < 4; b++) begin
            if (avs_byteenable[b]) shadow_reg[gi][8*b +: 8] <= avs_writedata[8*b +: 8];
          end
        end
      end

      always_ff @(posedge clk) begin
        if (reset) packet_reg[gi] <= '0;
        else if (load) packet_reg[gi] <= shadow_reg[gi];
      end

      if (gi < 8) begin : g_mid
        assign work_midstate[gi*32 +: 32] = packet_reg[gi];
      end else begin : g_dat
        assign work_data[(gi-8)*32 +: 32] = packet_reg[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_reg    <= 1'b0;
      overflow_reg   <= 1'b0;
      commit_err_reg <= 1'b0;
    end else begin
      if (load) pending_reg <= 1'b1;
      else if (accept) pending_reg <= 1'b0;
      // Set events take priority over a same-cycle write-1-to-clear.
      overflow_reg   <= ovf_set  || (overflow_reg   && !ovf_clr);
      commit_err_reg <= cerr_set || (commit_err_reg && !cerr_clr);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= nonce;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Read mux sees pre-edge state, so a same-cycle write is not reflected.
  always_comb begin
    rd_mux = '0;
    if (avs_address <= 4'd10) rd_mux = shadow_reg[avs_address];
    else if (avs_address == ADDR_STATUS) rd_mux = status_word;
    else if (avs_address == ADDR_POP && !fifo_empty) rd_mux = fifo_mem[rd_ptr_reg];
  end

  always_ff @(posedge clk) begin
    if (reset) readdata_reg <= '0;
    else if (avs_read) readdata_reg <= rd_mux;
  end

  assign avs_readdata = readdata_reg;
  assign work_valid   = pending_reg;

endmodule

// File: tb/tb_fpgaminer_avmm_work_regs.sv
// Self-checking bench: queued expectations for register reads, direct checks on the packet port.
module tb_fpgaminer_avmm_work_regs;
  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [3:0]   avs_address = '0;
  logic         avs_write = 1'b0;
  logic [31:0]  avs_writedata = '0;
  logic [3:0]   avs_byteenable = '0;
  logic         avs_read = 1'b0;
  logic [31:0]  avs_readdata;
  logic         work_valid;
  logic         work_ready = 1'b0;
  logic [255:0] work_midstate;
  logic [95:0]  work_data;
  logic         nonce_valid = 1'b0;
  logic [31:0]  nonce = '0;

  int n_cmp = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];
  logic [31:0] shadow_m [0:10];
  logic [31:0] exp_v;

  fpgaminer_avmm_work_regs #(.FIFO_DEPTH(4), .W1C_ENABLE(1'b1)) dut (
    .clk(clk), .reset(reset), .avs_address(avs_address), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable), .avs_read(avs_read),
    .avs_readdata(avs_readdata), .work_valid(work_valid), .work_ready(work_ready),
    .work_midstate(work_midstate), .work_data(work_data), .nonce_valid(nonce_valid), .nonce(nonce)
  );

  always #5 clk = ~clk;

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    avs_address = a; avs_writedata = d; avs_byteenable = be; avs_write = 1'b1;
    @(negedge clk);
    avs_write = 1'b0;
    $display("wr addr=%0d data=%08h be=%b", a, d, be);
  endtask

  task automatic bus_read(input logic [3:0] a);
    @(negedge clk);
    avs_address = a; avs_read = 1'b1;
    @(negedge clk);
    avs_read = 1'b0;
    $display("rd addr=%0d data=%08h", a, avs_readdata);
  endtask

  task automatic test_reset;
    reset = 1'b1; work_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0; work_ready = 1'b0;
    n_cmp++; if (work_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", work_valid); end
    n_cmp++; if (avs_readdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %08h want 0", avs_readdata); end
    exp_q.push_back(32'h0); bus_read(4'd12);
    exp_v = exp_q.pop_front();
    n_cmp++; if (avs_readdata !== exp_v) begin n_fail++; $display("FAIL reset_status got %08h want %08h", avs_readdata, exp_v); end
  endtask

  task automatic test_commit;
    for (int i = 0; i < 11; i++) begin
      bus_write(4'(i), 32'(i), 4'hF);
      shadow_m[i] = 32'(i);
    end
    bus_write(4'd11, 32'h1, 4'hF);
    n_cmp++; if (work_valid !== 1'b1) begin n_fail++; $display("FAIL commit_valid got %b want 1", work_valid); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (work_midstate[i*32 +: 32] !== shadow_m[i]) begin n_fail++; $display("FAIL commit_mid%0d got %08h want %08h", i, work_midstate[i*32 +: 32], shadow_m[i]); end
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (work_data[i*32 +: 32] !== shadow_m[8+i]) begin n_fail++; $display("FAIL commit_data%0d got %08h want %08h", i, work_data[i*32 +: 32], shadow_m[8+i]); end
    end
    exp_q.push_back(32'h1); bus_read(4'd12);
    exp_v = exp_q.pop_front();
    n_cmp++; if (avs_readdata !== exp_v) begin n_fail++; $display("FAIL commit_status got %08h want %08h", avs_readdata, exp_v); end
    exp_q.push_back(32'd5); bus_read(4'd5);
    exp_v = exp_q.pop_front();
    n_cmp++; if (avs_readdata !== exp_v) begin n_fail++; $display("FAIL shadow_rd5 got %08h want %08h", avs_readdata, exp_v); end
    exp_q.push_back(32'h0); bus_read(4'd11);
    exp_v = exp_q.pop_front();
    n_cmp++; if (avs_readdata !== exp_v) begin n_fail++; $display("FAIL ctrl_rd got %08h want %08h", avs_readdata, exp_v); end
  endtask

  task automatic test_commit_err;
    bus_write(4'd0, 32'h55, 4'hF);
    bus_write(4'd11, 32'h1, 4'hF);
    n_cmp++; if (work_midstate[31:0] !== 32'h0) begin n_fail++; $display("FAIL cerr_packet got %08h want 0", work_midstate[31:0]); end
    exp_q.push_back(32'h101); bus_read(4'd12);
    exp_v = exp_q.pop_front();
    n_cmp++; if (avs_readdata !== exp_v) begin n_fail++; $display("FAIL cerr_status got %08h want %08h", avs_readdata, exp_v); end
    bus_write(4'd12, 32'h100, 4'hF);
    exp_q.push_back(32'h1); bus_read(4'd12);
    exp_v = exp_q.pop_front();
    n_cmp++; if (avs_readdata !== exp_v) begin n_fail++; $display("FAIL cerr_clear got %08h want %08h", avs_readdata, exp_v); end
  endtask

  task automatic test_back_to_back;
    bus_write(4'd0, 32'hAA, 4'hF);
    @(negedge clk);
    avs_address = 4'd11; avs_writedata = 32'h1; avs_byteenable = 4'hF; avs_write = 1'b1; work_ready = 1'b1;
    @(negedge clk);
    avs_write = 1'b0; work_ready = 1'b0;
    n_cmp++; if (work_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid got %b want 1", work_valid); end
    n_cmp++; if (work_midstate[31:0] !== 32'hAA) begin n_fail++; $display("FAIL b2b_word0 got %08h want 000000aa", work_midstate[31:0]); end
    exp_q.push_back(32'h1); bus_read(4'd12);
    exp_v = exp_q.pop_front();
    n_cmp++; if (avs_readdata !== exp_v) begin n_fail++; $display("FAIL b2b_status got %08h want %08h", avs_readdata, exp_v); end
    @(negedge clk); work_ready = 1'b1;
    @(negedge clk); work_ready = 1'b0;
    n_cmp++; if (work_valid !== 1'b0) begin n_fail++; $display("FAIL accept_valid got %b want 0", work_valid); end
    n_cmp++; if (work_midstate[31:0] !== 32'hAA) begin n_fail++; $display("FAIL accept_hold got %08h want 000000aa", work_midstate[31:0]); end
  endtask

  task automatic test_fifo;
    logic [31:0] fifo_m[$];
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); nonce_valid = 1'b1; nonce = 32'h11 + 32'(i);
      if (fifo_m.size() < 4) fifo_m.push_back(nonce);
    end
    @(negedge clk); nonce_valid = 1'b0;
    exp_q.push_back(32'h92); bus_read(4'd12);
    exp_v = exp_q.pop_front();
    n_cmp++; if (avs_readdata !== exp_v) begin n_fail++; $display("FAIL fifo_status got %08h want %08h", avs_readdata, exp_v); end
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(fifo_m.size() > 0 ? fifo_m.pop_front() : 32'h0);
      bus_read(4'd13);
      exp_v = exp_q.pop_front();
      n_cmp++; if (avs_readdata !== exp_v) begin n_fail++; $display("FAIL pop%0d got %08h want %08h", i, avs_readdata, exp_v); end
    end
    bus_write(4'd12, 32'h80, 4'hF);
    exp_q.push_back(32'h0); bus_read(4'd12);
    exp_v = exp_q.pop_front();
    n_cmp++; if (avs_readdata !== exp_v) begin n_fail++; $display("FAIL ovf_clear got %08h want %08h", avs_readdata, exp_v); end
    // Fill, then push and pop together while full.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); nonce_valid = 1'b1; nonce = 32'h21 + 32'(i); fifo_m.push_back(nonce);
    end
    @(negedge clk);
    nonce = 32'h25; avs_address = 4'd13; avs_read = 1'b1;
    exp_q.push_back(fifo_m.pop_front()); fifo_m.push_back(nonce);
    @(negedge clk); nonce_valid = 1'b0; avs_read = 1'b0;
    exp_v = exp_q.pop_front();
    n_cmp++; if (avs_readdata !== exp_v) begin n_fail++; $display("FAIL fullpop got %08h want %08h", avs_readdata, exp_v); end
    exp_q.push_back(32'h12); bus_read(4'd12);
    exp_v = exp_q.pop_front();
    n_cmp++; if (avs_readdata !== exp_v) begin n_fail++; $display("FAIL fullpop_status got %08h want %08h", avs_readdata, exp_v); end
    while (fifo_m.size() > 0) begin
      exp_q.push_back(fifo_m.pop_front()); bus_read(4'd13);
      exp_v = exp_q.pop_front();
      n_cmp++; if (avs_readdata !== exp_v) begin n_fail++; $display("FAIL drain got %08h want %08h", avs_readdata, exp_v); end
    end
  endtask

  task automatic test_byteenable_reset;
    bus_write(4'd3, 32'h0, 4'hF);
    bus_write(4'd3, 32'hFFFFFFFF, 4'b0101);
    exp_q.push_back(32'h00FF00FF); bus_read(4'd3);
    exp_v = exp_q.pop_front();
    n_cmp++; if (avs_readdata !== exp_v) begin n_fail++; $display("FAIL byteen got %08h want %08h", avs_readdata, exp_v); end
    repeat (3) @(negedge clk);
    n_cmp++; if (avs_readdata !== 32'h00FF00FF) begin n_fail++; $display("FAIL rdata_hold got %08h want 00ff00ff", avs_readdata); end
    // Read and write of the same word in one cycle returns the old value.
    @(negedge clk);
    avs_address = 4'd2; avs_writedata = 32'h1234; avs_byteenable = 4'hF; avs_write = 1'b1; avs_read = 1'b1;
    exp_q.push_back(32'd2);
    @(negedge clk); avs_write = 1'b0; avs_read = 1'b0;
    exp_v = exp_q.pop_front();
    n_cmp++; if (avs_readdata !== exp_v) begin n_fail++; $display("FAIL rw_same got %08h want %08h", avs_readdata, exp_v); end
    exp_q.push_back(32'h1234); bus_read(4'd2);
    exp_v = exp_q.pop_front();
    n_cmp++; if (avs_readdata !== exp_v) begin n_fail++; $display("FAIL rw_after got %08h want %08h", avs_readdata, exp_v); end
    bus_write(4'd11, 32'h1, 4'hF);
    n_cmp++; if (work_valid !== 1'b1) begin n_fail++; $display("FAIL pre_reset_valid got %b want 1", work_valid); end
    @(negedge clk); reset = 1'b1; work_ready = 1'b1;
    @(negedge clk); reset = 1'b0; work_ready = 1'b0;
    n_cmp++; if (work_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b want 0", work_valid); end
    n_cmp++; if (work_midstate !== 256'h0 || work_data !== 96'h0) begin n_fail++; $display("FAIL rst_packet got %h/%h want 0", work_midstate, work_data); end
    for (int a = 0; a < 16; a++) begin
      exp_q.push_back(32'h0); bus_read(4'(a));
      exp_v = exp_q.pop_front();
      n_cmp++; if (avs_readdata !== exp_v) begin n_fail++; $display("FAIL rst_rd%0d got %08h want %08h", a, avs_readdata, exp_v); end
    end
  endtask

  initial begin
    test_reset();
    test_commit();
    test_commit_err();
    test_back_to_back();
    test_fifo();
    test_byteenable_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/fpgaminer_avmm_work_regs.md
FPGAMINER_AVMM_WORK_REGS -- requirements
Module: fpgaminer_avmm_work_regs

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, is the nonce result FIFO depth (power of 2, 2..16).
REQ-002 Parameter W1C_ENABLE, default 1: when 1, STATUS sticky bits clear on write-1; when 0, STATUS writes are ignored.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 avs_address  input  4  Avalon-MM word address.
REQ-006 avs_write  input  1  write strobe.
REQ-007 avs_writedata  input  32  write data.
REQ-008 avs_byteenable  input  4  byte lanes for writes.
REQ-009 avs_read  input  1  read strobe.
REQ-010 avs_readdata  output  32  read data, fixed read latency 1.
REQ-011 work_valid  output  1  work packet available to hash core.
REQ-012 work_ready  input  1  hash core accepts packet.
REQ-013 work_midstate  output  256  word0 in [31:0] ... word7 in [255:224].
REQ-014 work_data  output  96  word8 in [31:0] ... word10 in [95:64].
REQ-015 nonce_valid  input  1  one-cycle golden-nonce pulse from core, no backpressure.
REQ-016 nonce  input  32  golden nonce value.

Function
REQ-017 Address map: 0-7 midstate shadow, 8-10 data shadow, 11 CTRL, 12 STATUS, 13 NONCE_POP, 14-15 unmapped; no waitrequest (never stalls).
REQ-018 Writes to 0-10 update the shadow word per enabled byte lane only; disabled lanes retain value.
REQ-019 Write to CTRL with writedata[0]=1 (byteenable[0]=1) is a commit; other CTRL bits are ignored.
REQ-020 Commit with pending=0, or with pending=1 and work_valid&work_ready in the same cycle: copy all 11 shadow words to the output packet registers next cycle and set pending=1.
REQ-021 Commit with pending=1 and no acceptance that cycle: packet unchanged, commit_err sticky set.
REQ-022 work_valid equals pending; pending clears on work_valid&work_ready unless a same-cycle commit reloads it; packet outputs are stable while work_valid=1.
REQ-023 Shadow registers are never modified by commit or acceptance; a commit back-to-back with a shadow write captures the write if the write occurred in an earlier cycle.
REQ-024 nonce_valid pushes nonce into FIFO; push while full and no same-cycle pop drops the nonce and sets overflow sticky.
REQ-025 Read of NONCE_POP returns FIFO head and pops it; if empty returns 0x00000000 and no pop; simultaneous push and pop when full succeeds without overflow.
REQ-026 STATUS read: [0] pending, [1] FIFO non-empty, [6:2] FIFO count, [7] overflow, [8] commit_err, others 0.
REQ-027 STATUS write with W1C_ENABLE=1: writedata[7]/[8] = 1 clears overflow/commit_err; a same-cycle set event wins over clear.
REQ-028 Reads of 0-10 return shadow; CTRL and 14-15 read as 0; readdata holds last value when no read.
REQ-029 Read and write in the same cycle: write is performed; read returns pre-write value.

Reset
REQ-030 reset=1 at a clock edge clears shadow, packet, pending, FIFO pointers/count, sticky bits and avs_readdata to 0; work_valid=0 the next cycle.
REQ-031 reset mid-handshake discards the packet; a work_ready seen during reset has no effect.

Verification
REQ-032 Write words 0-10 with data i, commit, work_ready=0 -> work_valid=1, work_midstate[31:0]=0, [255:224]=7, work_data[95:64]=10; STATUS=0x1.
REQ-033 Pending packet, second commit without ready -> packet unchanged, STATUS[8]=1; write STATUS 0x100 -> STATUS[8]=0.
REQ-034 Commit in same cycle as work_ready=1 with shadow word0=0xAA -> work_valid stays 1, work_midstate[31:0]=0xAA.
REQ-035 Push 5 nonces 0x11..0x15 with FIFO_DEPTH=4 -> STATUS count=4, [7]=1; pops return 0x11..0x14, fifth pop returns 0.
REQ-036 Write 0xFFFFFFFF to word 3 with byteenable=4'b0101 over 0 -> reads 0x00FF00FF; assert reset -> all reads and work_valid 0.
